delay_calibrator: RTL and testbench

Measures the latency, in clock cycles, of an external delay path such as a shift-register delay chain. It drives one-cycle probe pulses into the path, times each echo returning on its output, and reports the minimum and maximum delay over a burst of probes. It sits on the far side of a delay path and is used to check or calibrate clock and strobe delay stages in simulation and bring-up.

---
 rtl/delay_calibrator_if.sv | 25 ++
 rtl/delay_calibrator.sv | 159 +++++++++++++++
 tb/tb_delay_calibrator.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/delay_calibrator_if.sv
// Probe/echo and result bundle for delay_calibrator.
// The master side (stimulus/system) drives start and echo_in; the slave side is the calibrator.
interface delay_calibrator_if #(
   parameter int CNT_W = 8
);
   logic             start;
   logic             echo_in;
   logic             probe_out;
   logic             busy;
   logic             done;
   logic             timeout;
   logic [CNT_W-1:0] delay_min;
   logic [CNT_W-1:0] delay_max;
   logic             mismatch;

   modport master (
      output start, echo_in,
      input  probe_out, busy, done, timeout, delay_min, delay_max, mismatch
   );

   modport slave (
      input  start, echo_in,
      output probe_out, busy, done, timeout, delay_min, delay_max, mismatch
   );
endinterface

// File: rtl/delay_calibrator.sv
// Measures echo latency of an external delay path over a burst of probes,
// reporting min/max delay, with guard-quiet, timeout and mismatch detection.
module delay_calibrator #(
   parameter int CNT_W        = 8,
   parameter int MAX_WAIT     = 255,
   parameter int NUM_PROBES   = 4,
   parameter int GUARD_CYCLES = 4
) (
   input logic              clk,
   input logic              rst_n,
   delay_calibrator_if.slave bus
);
   localparam int PW = (NUM_PROBES > 1) ? $clog2(NUM_PROBES) : 1;
   localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(MAX_WAIT - 1);
   localparam logic [GW-1:0]    GUARD_LAST = GW'(GUARD_CYCLES - 1);
   localparam logic [PW-1:0]    PROBE_LAST = PW'(NUM_PROBES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_QUIET = 3'd1,
      S_SEND  = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           state_r;
   logic [GW-1:0]    guard_r;
   logic [CNT_W-1:0] stall_r;
   logic [CNT_W-1:0] cnt_r;
   logic [PW-1:0]    probe_idx_r;
   logic [CNT_W-1:0] wmin_r;
   logic [CNT_W-1:0] wmax_r;
   logic             probe_r;
   logic             busy_r;
   logic             done_r;
   logic             timeout_r;
   logic [CNT_W-1:0] dmin_r;
   logic [CNT_W-1:0] dmax_r;
   logic             mismatch_r;
   logic [CNT_W-1:0] cap_min_s;
   logic [CNT_W-1:0] cap_max_s;

   // Working min/max including the delay captured this cycle
   always_comb begin
      cap_min_s = wmin_r;
      cap_max_s = wmax_r;
      if (cnt_r < wmin_r) begin
         cap_min_s = cnt_r;
      end else begin
         cap_min_s = wmin_r;
      end
      if (cnt_r > wmax_r) begin
         cap_max_s = cnt_r;
      end else begin
         cap_max_s = wmax_r;
      end
   end

   // Measurement FSM with registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_IDLE;
         guard_r     <= {GW{1'b0}};
         stall_r     <= {CNT_W{1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         probe_idx_r <= {PW{1'b0}};
         wmin_r      <= {CNT_W{1'b1}};
         wmax_r      <= {CNT_W{1'b0}};
         probe_r     <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         timeout_r   <= 1'b0;
         dmin_r      <= {CNT_W{1'b0}};
         dmax_r      <= {CNT_W{1'b0}};
         mismatch_r  <= 1'b0;
      end else begin
         probe_r <= 1'b0;
         done_r  <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (bus.start) begin
                  state_r     <= S_QUIET;
                  busy_r      <= 1'b1;
                  timeout_r   <= 1'b0;
                  probe_idx_r <= {PW{1'b0}};
                  wmin_r      <= {CNT_W{1'b1}};
                  wmax_r      <= {CNT_W{1'b0}};
                  guard_r     <= {GW{1'b0}};
                  stall_r     <= {CNT_W{1'b0}};
               end else begin
                  busy_r <= 1'b0;
               end
            end
            S_QUIET: begin
               stall_r <= stall_r + CNT_W'(1);
               if (!bus.echo_in && (guard_r == GUARD_LAST)) begin
                  state_r <= S_SEND;
                  probe_r <= 1'b1;
                  cnt_r   <= {CNT_W{1'b0}};
               end else if (stall_r == WAIT_LAST) begin
                  state_r   <= S_DONE;
                  done_r    <= 1'b1;
                  timeout_r <= 1'b1;
               end else if (bus.echo_in) begin
                  guard_r <= {GW{1'b0}};
               end else begin
                  guard_r <= guard_r + GW'(1);
               end
            end
            S_SEND: begin
               // echo_in is deliberately ignored here: minimum delay is 1
               state_r <= S_WAIT;
               cnt_r   <= cnt_r + CNT_W'(1);
            end
            S_WAIT: begin
               if (bus.echo_in) begin
                  wmin_r <= cap_min_s;
                  wmax_r <= cap_max_s;
                  if (probe_idx_r == PROBE_LAST) begin
                     state_r    <= S_DONE;
                     done_r     <= 1'b1;
                     dmin_r     <= cap_min_s;
                     dmax_r     <= cap_max_s;
                     mismatch_r <= (cap_min_s != cap_max_s);
                  end else begin
                     state_r     <= S_QUIET;
                     probe_idx_r <= probe_idx_r + PW'(1);
                     guard_r     <= {GW{1'b0}};
                     stall_r     <= {CNT_W{1'b0}};
                  end
               end else if (cnt_r == WAIT_LAST) begin
                  state_r   <= S_DONE;
                  done_r    <= 1'b1;
                  timeout_r <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            S_DONE: begin
               state_r <= S_IDLE;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r <= S_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.probe_out = probe_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.timeout   = timeout_r;
   assign bus.delay_min = dmin_r;
   assign bus.delay_max = dmax_r;
   assign bus.mismatch  = mismatch_r;
endmodule

// File: tb/tb_delay_calibrator.sv
// Randomized bench for delay_calibrator: an echo-path model plus a timeline
// model predicting probe/done cycles and results from the delays in each run.
module tb_delay_calibrator;
   localparam int CW = 8;
   localparam int MW = 255;
   localparam int NP = 4;
   localparam int G  = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   delay_calibrator_if #(.CNT_W(CW)) bus ();

   delay_calibrator #(
      .CNT_W(CW), .MAX_WAIT(MW), .NUM_PROBES(NP), .GUARD_CYCLES(G)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int errors = 0;
   int checks = 0;
   int c = 0;
   int mode = 0;            // 0: delay chain, 1: dead path, 2: stuck high
   bit start_now = 1'b0;
   int delay_q[$];
   bit echo_at[int];
   int cur_min = 0, cur_max = 0, cur_to = 0, cur_mm = 0;
   int last_s, last_done;
   int last_p[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, c, act, exp);
      end
   endtask

   // One clock cycle: compare outputs, then drive inputs for this cycle
   task automatic step(input bit e_busy, input bit e_probe, input bit e_done);
      @(negedge clk);
      chk("busy",      32'(bus.busy),      32'(e_busy));
      chk("probe_out", 32'(bus.probe_out), 32'(e_probe));
      chk("done",      32'(bus.done),      32'(e_done));
      chk("timeout",   32'(bus.timeout),   cur_to);
      chk("delay_min", 32'(bus.delay_min), cur_min);
      chk("delay_max", 32'(bus.delay_max), cur_max);
      chk("mismatch",  32'(bus.mismatch),  cur_mm);
      if (bus.probe_out === 1'b1 && mode == 0 && delay_q.size() > 0)
         echo_at[c + delay_q.pop_front()] = 1'b1;
      bus.echo_in = (mode == 2) ? 1'b1 : (mode == 1) ? 1'b0 : (echo_at.exists(c) != 0);
      bus.start   = start_now;
      c++;
   endtask

   task automatic idle(input int n);
      start_now = 1'b0;
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_probe",    32'(bus.probe_out), 32'd0);
      chk("rst_busy",     32'(bus.busy),      32'd0);
      chk("rst_done",     32'(bus.done),      32'd0);
      chk("rst_timeout",  32'(bus.timeout),   32'd0);
      chk("rst_min",      32'(bus.delay_min), 32'd0);
      chk("rst_max",      32'(bus.delay_max), 32'd0);
      chk("rst_mismatch", 32'(bus.mismatch),  32'd0);
      cur_min = 0; cur_max = 0; cur_to = 0; cur_mm = 0;
      echo_at.delete();
      delay_q.delete();
      start_now   = 1'b0;
      bus.start   = 1'b0;
      bus.echo_in = 1'b0;
      repeat (2) @(negedge clk);
      c += 2;
      rst_n = 1'b1;
   endtask

   // Predict the whole measurement timeline from the probe delays, then walk it
   task automatic run_meas(input int m, input int d[4], input bit mid_start, input bit abort);
      int s, done_c, np, to, mn, mx;
      int p[4];
      bit pr;
      mode = m;
      s = c;
      p[0] = s + 1 + G;
      for (int k = 1; k < 4; k++) p[k] = p[k-1] + d[k-1] + 1 + G;
      mn = d[0]; mx = d[0];
      for (int k = 1; k < 4; k++) begin
         if (d[k] < mn) mn = d[k];
         if (d[k] > mx) mx = d[k];
      end
      case (m)
         0:       begin np = 4; done_c = p[3] + d[3] + 1; to = 0; end
         1:       begin np = 1; done_c = p[0] + MW;       to = 1; end
         default: begin np = 0; done_c = s + 1 + MW;      to = 1; end
      endcase
      if (m == 0) for (int k = 0; k < 4; k++) delay_q.push_back(d[k]);
      for (int cy = s; cy <= done_c + 1; cy++) begin
         if (abort && cy == p[0] + 3) begin
            do_reset();
            mode = 0;
            return;
         end
         pr = 1'b0;
         for (int k = 0; k < np; k++) if (p[k] == cy) pr = 1'b1;
         if (cy == s + 1) cur_to = 0;
         if (cy == done_c) begin
            cur_to = to;
            if (to == 0) begin
               cur_min = mn; cur_max = mx; cur_mm = (mn != mx) ? 1 : 0;
            end
         end
         start_now = (cy == s) || (mid_start && cy == p[0] + 1);
         step(cy > s && cy <= done_c, pr, cy == done_c);
      end
      start_now = 1'b0;
      mode = 0;
      last_s = s;
      last_done = done_c;
      last_p = p;
   endtask

   initial begin
      int rd[4];
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.echo_in = 1'b0;
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      idle(2);

      // Nominal 6-flop chain
      run_meas(0, '{6, 6, 6, 6}, 1'b0, 1'b0);
      chk("nom_probe0_lat", last_p[0] - last_s, 32'd5);
      chk("nom_probe3_lat", last_p[3] - last_s, 32'd38);
      chk("nom_done_lat",   last_done - last_s, 32'd45);
      chk("nom_min_lit",    32'(bus.delay_min), 32'd6);
      chk("nom_mm_lit",     32'(bus.mismatch),  32'd0);
      idle(3);

      // Dead path: one probe then timeout, results retained
      run_meas(1, '{0, 0, 0, 0}, 1'b0, 1'b0);
      chk("dead_lat",     last_done - last_p[0], 32'd255);
      chk("dead_min_lit", 32'(bus.delay_min), 32'd6);
      chk("dead_to_lit",  32'(bus.timeout),   32'd1);
      idle(2);

      // Stuck-high echo: never probes
      run_meas(2, '{0, 0, 0, 0}, 1'b0, 1'b0);
      chk("stuck_lat", last_done - (last_s + 1), 32'd255);
      idle(2);

      // Alternating delays
      run_meas(0, '{5, 7, 5, 7}, 1'b0, 1'b0);
      chk("vary_min_lit", 32'(bus.delay_min), 32'd5);
      chk("vary_max_lit", 32'(bus.delay_max), 32'd7);
      chk("vary_mm_lit",  32'(bus.mismatch),  32'd1);
      idle(2);

      // Start pulse while busy must be ignored
      run_meas(0, '{6, 6, 6, 6}, 1'b1, 1'b0);
      chk("ign_done_lat", last_done - last_s, 32'd45);
      idle(2);

      // Reset mid-WAIT, then a clean run
      run_meas(0, '{6, 6, 6, 6}, 1'b0, 1'b1);
      idle(2);
      run_meas(0, '{6, 6, 6, 6}, 1'b0, 1'b0);
      chk("post_rst_min_lit", 32'(bus.delay_min), 32'd6);
      idle(1);

      // Randomized delays, gaps and busy-time start pulses
      for (int r = 0; r < 20; r++) begin
         for (int k = 0; k < 4; k++) rd[k] = int'($urandom_range(40, 1));
         run_meas(0, rd, 1'($urandom_range(1, 0)), 1'b0);
         idle(int'($urandom_range(5, 0)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
